// File: rtl/disp_pkg.sv
// disp_pkg: shared constants for the scanned 7-segment display scheduler.
//   SEG_TABLE  : active-low segment patterns for hex digits 0..F (bit7 = DP, off)
//   SEG_BLANK  : pattern for a dark digit
//   AN_OFF     : all digit enables inactive
//   NUM_DIGITS : digits per display frame
//   NUM_SRC    : number of selectable 32-bit sources
package disp_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int NUM_SRC    = 4;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Index 0 is the rightmost entry: SEG_TABLE[4'h0] = 8'hC0.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h98, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/hex_seg_enc.sv
// hex_seg_enc: combinational hex nibble to active-low 7-segment pattern.
//   code_i : 4-bit hex digit
//   patt_o : 8-bit segment drive, active-low, bit7 (DP) always 1
module hex_seg_enc
  import disp_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [7:0] patt_o
);

  assign patt_o = SEG_TABLE[code_i];

endmodule

// File: rtl/disp_scan_sched.sv
// disp_scan_sched: frame-coherent scan scheduler for an 8-digit active-low
// 7-segment display shared between four 32-bit hex sources.
//   clk, rst  : system clock, asynchronous active-high reset
//   src_data  : four 32-bit sources, source i at [32*i+31:32*i]
//   src_valid : per-source capture strobe into the snapshot registers
//   auto_mode : 1 = rotate sources every ROTATE_FRAMES frames, 0 = use sel
//   sel       : manual source index
//   blank_en  : blank leading zero digits
//   an        : digit enables, active-low, at most one low
//   patt      : segment drive, active-low, bit7 = DP (always 1)
//   cur_src   : index of the source whose frame is being displayed
module disp_scan_sched
  import disp_pkg::*;
#(
  parameter int SCAN_DIV      = 100000,
  parameter int ROTATE_FRAMES = 512
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] src_data,
  input  logic [3:0]   src_valid,
  input  logic         auto_mode,
  input  logic [1:0]   sel,
  input  logic         blank_en,
  output logic [7:0]   an,
  output logic [7:0]   patt,
  output logic [1:0]   cur_src
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = $clog2(ROTATE_FRAMES + 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic [2:0]    dig_q, dig_d;
  logic          frame_end;

  logic [NUM_SRC-1:0][31:0] snap_q;
  logic [31:0]   frame_q;
  logic [1:0]    cur_src_q, next_src;
  logic [FW-1:0] fcnt_q, fcnt_d;

  logic [2:0]    msd;
  logic [3:0]    cur_nib;
  logic [7:0]    enc_patt;
  logic          blank;
  logic [7:0]    an_q, patt_q;

  // ---------------- prescaler and digit sequencer ----------------
  assign tick      = (presc_q == PW'(SCAN_DIV - 1));
  assign frame_end = tick && (dig_q == 3'd7);

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    dig_d   = tick ? dig_q + 3'd1 : dig_q;
  end

  // dig_q is the digit that will be driven at the next tick; it starts at 0
  // so the first visible digit after reset is digit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      dig_q   <= '0;
    end else begin
      presc_q <= presc_d;
      dig_q   <= dig_d;
    end
  end

  // ---------------- source snapshots ----------------
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_snap
    always_ff @(posedge clk or posedge rst) begin
      if (rst)               snap_q[i] <= '0;
      else if (src_valid[i]) snap_q[i] <= src_data[32*i +: 32];
    end
  end

  // ---------------- source arbitration ----------------
  always_comb begin
    next_src = cur_src_q;
    fcnt_d   = fcnt_q;
    if (!auto_mode) begin
      next_src = sel;
      fcnt_d   = '0;
    end else if (fcnt_q == FW'(ROTATE_FRAMES - 1)) begin
      next_src = cur_src_q + 2'd1;
      fcnt_d   = '0;
    end else begin
      fcnt_d   = fcnt_q + FW'(1);
    end
  end

  // Frame buffer and cur_src change only at a frame end, so a frame is never
  // torn. A snapshot written on the frame-end edge is read here as its old
  // value and appears one frame later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q   <= '0;
      cur_src_q <= '0;
    end else if (frame_end) begin
      frame_q   <= snap_q[next_src];
      cur_src_q <= next_src;
    end
  end

  // Counter is pinned at 0 while in manual so that auto restarts cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            fcnt_q <= '0;
    else if (!auto_mode) fcnt_q <= '0;
    else if (frame_end) fcnt_q <= fcnt_d;
  end

  // ---------------- leading-zero blanking ----------------
  always_comb begin
    msd = 3'd0;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (frame_q[4*n +: 4] != 4'h0) msd = 3'(n);
    end
  end

  assign cur_nib = frame_q[4*dig_q +: 4];
  assign blank   = blank_en && (dig_q > msd);

  hex_seg_enc u_enc (
    .code_i (cur_nib),
    .patt_o (enc_patt)
  );

  // ---------------- registered outputs ----------------
  // an and patt load on the same edge from the same dig_q, so they always
  // refer to the same digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q   <= AN_OFF;
      patt_q <= SEG_BLANK;
    end else if (tick) begin
      an_q   <= ~(8'd1 << dig_q);
      patt_q <= blank ? SEG_BLANK : enc_patt;
    end
  end

  assign an      = an_q;
  assign patt    = patt_q;
  assign cur_src = cur_src_q;

endmodule

// File: tb/tb_disp_scan_sched.sv
module tb_disp_scan_sched;

  logic         clk;
  logic         rst;
  logic [127:0] src_data;
  logic [3:0]   src_valid;
  logic         auto_mode;
  logic [1:0]   sel;
  logic         blank_en;
  logic [7:0]   an;
  logic [7:0]   patt;
  logic [1:0]   cur_src;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [7:0] exp_man [8] = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};
  logic [7:0] exp_blk [8] = '{8'h92, 8'hC0, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  disp_scan_sched #(.SCAN_DIV(4), .ROTATE_FRAMES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_data  (src_data),
    .src_valid (src_valid),
    .auto_mode (auto_mode),
    .sel       (sel),
    .blank_en  (blank_en),
    .an        (an),
    .patt      (patt),
    .cur_src   (cur_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle bookkeeping: cyc counts posedges since reset release; all sampling
  // happens on negedges.
  task automatic goto(input int c);
    repeat (c - cyc) @(negedge clk);
    cyc = c;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset;
    auto_mode = 1'b0; sel = 2'd0; blank_en = 1'b0; src_valid = 4'h0;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (an !== 8'hFF || patt !== 8'hFF || cur_src !== 2'd0) begin
      bad++;
      $display("FAIL reset_state: an=%h patt=%h cur_src=%0d want FF FF 0", an, patt, cur_src);
    end
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      goto(c);
      total++;
      if (an !== 8'hFF) begin
        bad++;
        $display("FAIL reset_idle_an c=%0d: an=%h want FF", c, an);
      end
    end
    for (int t = 0; t <= 8; t++) begin
      logic [7:0] ea;
      ea = ~(8'd1 << (t % 8));
      goto(4 + 4*t);
      total++;
      if (an !== ea || patt !== 8'hC0) begin
        bad++;
        $display("FAIL walk t=%0d: an=%h patt=%h want %h C0", t, an, patt, ea);
      end
    end
  endtask

  task automatic test_manual_and_torn;
    auto_mode = 1'b0; sel = 2'd1; blank_en = 1'b0; src_valid = 4'h0;
    do_reset();
    src_data[63:32] = 32'h1234_ABCD;
    src_valid = 4'b0010;
    goto(1);
    src_valid = 4'h0;
    goto(31);
    total++;
    if (cur_src !== 2'd0) begin
      bad++;
      $display("FAIL manual_pre_switch: cur_src=%0d want 0", cur_src);
    end
    goto(32);
    total++;
    if (cur_src !== 2'd1 || an !== 8'h7F || patt !== 8'hC0) begin
      bad++;
      $display("FAIL manual_switch: cur_src=%0d an=%h patt=%h want 1 7F C0", cur_src, an, patt);
    end
    for (int k = 0; k < 8; k++) begin
      goto(36 + 4*k);
      total++;
      if (an !== ~(8'd1 << k) || patt !== exp_man[k]) begin
        bad++;
        $display("FAIL manual_digit%0d: an=%h patt=%h want %h %h", k, an, patt, ~(8'd1 << k), exp_man[k]);
      end
    end
    // Mid-frame capture during frame 3 (cycles 68..96) must not tear it.
    goto(76);
    src_data[63:32] = 32'hFFFF_FFFF;
    src_valid = 4'b0010;
    goto(77);
    src_valid = 4'h0;
    for (int k = 3; k < 8; k++) begin
      goto(80 + 4*(k-3));
      total++;
      if (an !== ~(8'd1 << k) || patt !== exp_man[k]) begin
        bad++;
        $display("FAIL torn_old_digit%0d: an=%h patt=%h want %h %h", k, an, patt, ~(8'd1 << k), exp_man[k]);
      end
    end
    for (int k = 0; k < 8; k++) begin
      if (k == 7) begin
        // Capture lands exactly on the frame-end edge (cycle 128).
        goto(127);
        src_data[63:32] = 32'h0000_0007;
        src_valid = 4'b0010;
        goto(128);
        src_valid = 4'h0;
      end else begin
        goto(100 + 4*k);
      end
      total++;
      if (an !== ~(8'd1 << k) || patt !== 8'h8E) begin
        bad++;
        $display("FAIL torn_new_digit%0d: an=%h patt=%h want %h 8E", k, an, patt, ~(8'd1 << k));
      end
    end
    goto(132);
    total++;
    if (patt !== 8'h8E) begin
      bad++;
      $display("FAIL frame_end_capture_late: patt=%h want 8E", patt);
    end
    goto(164);
    total++;
    if (an !== 8'hFE || patt !== 8'hF8) begin
      bad++;
      $display("FAIL frame_end_capture_shown: an=%h patt=%h want FE F8", an, patt);
    end
  endtask

  task automatic test_auto_rotate;
    auto_mode = 1'b1; sel = 2'd0; blank_en = 1'b0; src_valid = 4'h0;
    do_reset();
    src_data = {32'd3, 32'd2, 32'd1, 32'd0};
    src_valid = 4'hF;
    goto(1);
    src_valid = 4'h0;
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] prv, nxt;
      prv = 2'((k - 1) % 4);
      nxt = 2'(k % 4);
      goto(64*k - 1);
      total++;
      if (cur_src !== prv) begin
        bad++;
        $display("FAIL auto_hold k=%0d: cur_src=%0d want %0d", k, cur_src, prv);
      end
      goto(64*k);
      total++;
      if (cur_src !== nxt) begin
        bad++;
        $display("FAIL auto_step k=%0d: cur_src=%0d want %0d", k, cur_src, nxt);
      end
      goto(64*k + 4);
      total++;
      if (an !== 8'hFE || patt !== seg_tab[nxt]) begin
        bad++;
        $display("FAIL auto_data k=%0d: an=%h patt=%h want FE %h", k, an, patt, seg_tab[nxt]);
      end
    end
  endtask

  task automatic test_blanking;
    auto_mode = 1'b0; sel = 2'd2; blank_en = 1'b1; src_valid = 4'h0;
    do_reset();
    src_data[95:64] = 32'h0000_0A05;
    src_valid = 4'b0100;
    goto(1);
    src_valid = 4'h0;
    for (int k = 0; k < 8; k++) begin
      logic [7:0] ep;
      ep = (k == 0) ? 8'hC0 : 8'hFF;
      goto(4 + 4*k);
      total++;
      if (an !== ~(8'd1 << k) || patt !== ep) begin
        bad++;
        $display("FAIL blank_zero_digit%0d: an=%h patt=%h want %h %h", k, an, patt, ~(8'd1 << k), ep);
      end
    end
    for (int k = 0; k < 8; k++) begin
      goto(36 + 4*k);
      total++;
      if (an !== ~(8'd1 << k) || patt !== exp_blk[k]) begin
        bad++;
        $display("FAIL blank_a05_digit%0d: an=%h patt=%h want %h %h", k, an, patt, ~(8'd1 << k), exp_blk[k]);
      end
    end
  endtask

  task automatic test_reset_mid;
    auto_mode = 1'b0; sel = 2'd3; blank_en = 1'b0; src_valid = 4'h0;
    do_reset();
    goto(52);
    total++;
    if (an !== 8'hEF || cur_src !== 2'd3) begin
      bad++;
      $display("FAIL mid_pre: an=%h cur_src=%0d want EF 3", an, cur_src);
    end
    rst = 1'b1;
    #1;
    total++;
    if (an !== 8'hFF || patt !== 8'hFF || cur_src !== 2'd0) begin
      bad++;
      $display("FAIL mid_async: an=%h patt=%h cur_src=%0d want FF FF 0", an, patt, cur_src);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    goto(3);
    total++;
    if (an !== 8'hFF) begin
      bad++;
      $display("FAIL mid_restart_idle: an=%h want FF", an);
    end
    goto(4);
    total++;
    if (an !== 8'hFE || patt !== 8'hC0 || cur_src !== 2'd0) begin
      bad++;
      $display("FAIL mid_restart_d0: an=%h patt=%h cur_src=%0d want FE C0 0", an, patt, cur_src);
    end
    goto(8);
    total++;
    if (an !== 8'hFD) begin
      bad++;
      $display("FAIL mid_restart_d1: an=%h want FD", an);
    end
  endtask

  initial begin
    rst = 1'b1;
    src_data = '0;
    src_valid = 4'h0;
    auto_mode = 1'b0;
    sel = 2'd0;
    blank_en = 1'b0;
    test_reset();
    test_manual_and_torn();
    test_auto_rotate();
    test_blanking();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/disp_scan_sched.md
Name: disp_scan_sched

Overview:
- Time-shares the 8-digit active-low 7-segment display between four 32-bit hex sources, e.g. PC, instruction, ALU result and memory data.
- Owns the scan prescaler, the digit sequencer and source selection (manual or auto-rotate).
- Keeps source snapshots and applies leading-zero blanking.
- Sits between the CPU debug taps and the board display pins. It replaces free-running per-clk scanning with a paced, frame-coherent scheduler.

Parameters:
- SCAN_DIV, 100000, clk cycles per digit slot (>=2).
- ROTATE_FRAMES, 512, full 8-digit frames per source in auto mode (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- src_data  in  128  four 32-bit sources; source i is at [32*i+31:32*i].
- src_valid  in  4  bit i high for one cycle captures source i into snapshot i.
- auto_mode  in  1  1 = rotate sources; 0 = manual via sel.
- sel  in  2  manual source index.
- blank_en  in  1  1 = blank leading zero digits.
- an  out  8  digit enables, active-low, one-hot-zero.
- patt  out  8  segment drive, active-low, bit7 = DP (always 1).
- cur_src  out  2  index of the source currently displayed.

Behaviour:
- Reset (async, immediate, also mid-operation): an=8'hFF, patt=8'hFF, cur_src=0. Prescaler=0, digit index=0, frame counter=0, all snapshots=0, frame buffer=0.
- Prescaler: counts 0..SCAN_DIV-1. tick is asserted in the cycle count==SCAN_DIV-1, then the count wraps to 0.
- Digit index d: 0..7. On tick, d<=d+1 with 7->0 wrap. A frame ends on the tick where d==7.
- Outputs are registered and updated on the clock edge of tick, aligned in the same cycle:
  - an=~(1<<d_next).
  - patt=enc(frame[4*d_next+3:4*d_next]), or 8'hFF if blanked.
  - an and patt must never refer to different digits.
- First visible digit is 0 (an=8'hFE), SCAN_DIV cycles after reset release. an stays 8'hFF until then.
- Digit 0 is the least significant nibble and is the rightmost display position.
- Snapshots: src_valid[i] loads snapshot i at the next edge, independent of scanning. Multiple bits may be set in the same cycle; all flagged snapshots load.
- Frame buffer: reloaded only at a frame end, from snapshot[next_src]. This prevents torn frames. A capture landing on the exact frame-end cycle is not seen in that reload; it is shown one frame later.
- Source selection, evaluated only at a frame end:
  - Manual: next_src=sel; the frame counter is held at 0.
  - Auto: the frame counter increments. When it equals ROTATE_FRAMES-1, next_src=cur_src+1 (3->0 wrap) and the counter clears. Otherwise next_src=cur_src.
  - Switching auto->manual or manual->auto takes effect at the next frame end. The counter restarts from 0 on entering auto.
- cur_src updates together with the frame buffer reload.
- Leading-zero blanking, computed on the frame buffer:
  - msd = index of the highest nonzero nibble; msd=0 if the value is 0.
  - With blank_en=1, digits d>msd output patt=8'hFF while an still strobes.
  - Value 0 therefore shows a single "0" on digit 0.
  - With blank_en=0, all digits are shown.
- Segment encoding, active-low:
  - 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8
  - 8:80, 9:98, A:88, b:83, C:C6, d:A1, E:86, F:8E
- No combinational path from any input to an/patt/cur_src.

Decomposition:
- Package disp_pkg: the 16-entry segment constant table, SEG_BLANK=8'hFF, AN_OFF=8'hFF, NUM_DIGITS=8, NUM_SRC=4.
- Sub-module hex_seg_enc: 4-bit code -> 8-bit patt, combinational, uses the package table.
- Sequencing, snapshot, blanking and arbitration logic stays in disp_scan_sched.

Test Plan (SCAN_DIV=4, ROTATE_FRAMES=2 unless noted):
- Reset then idle -> an=FF for 4 cycles. an then walks FE,FD,FB,...,7F,FE, one step per 4 cycles. With blank_en=0, patt=C0 throughout.
- Manual, sel=1, src1=32'h1234_ABCD captured, blank_en=0 -> from the next frame, digits 0..7 show D,C,B,A,4,3,2,1 = A1,C6,83,88,99,B0,A4,F9. cur_src=1.
- Mid-frame src_valid[1] with new value 32'hFFFF_FFFF -> the current frame completes with the old digits. The next frame shows 8E on all digits.
- Auto mode, sources 0..3 = 0,1,2,3 -> cur_src steps 0->1->2->3->0, every 2 frames (64 cycles), changing only at d=7 ticks.
- blank_en=1, value 32'h0000_0A05 -> digits 0..2 = 92,C0,88. Digits 3..7 patt=FF while an still strobes. Value 0 -> only digit 0 = C0.
- rst asserted mid-frame (d=5) -> an/patt go FF asynchronously and state clears. After release, the sequence restarts at digit 0 after 4 cycles.
